// File: rtl/reg_exec_sequencer.sv
// Multi-cycle execute controller placed in front of a 4-entry register file.
// Each instruction takes four cycles: accept, operand read, execute, write-back.
// HALT parks the sequencer until reset.
module reg_exec_sequencer #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ADDR_W  = 2,
   parameter int unsigned INSTR_W = 9
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   output logic [ADDR_W-1:0]  reg1,
   output logic [ADDR_W-1:0]  reg2,
   input  logic [DATA_W-1:0]  data1,
   input  logic [DATA_W-1:0]  data2,
   output logic [ADDR_W-1:0]  reg_write,
   output logic               do_write,
   output logic [DATA_W-1:0]  write_data,
   output logic               carry,
   output logic               zero,
   output logic               halted
);

   localparam logic [2:0] OpAdd  = 3'b000;
   localparam logic [2:0] OpSub  = 3'b001;
   localparam logic [2:0] OpAnd  = 3'b010;
   localparam logic [2:0] OpXor  = 3'b011;
   localparam logic [2:0] OpShl  = 3'b100;
   localparam logic [2:0] OpLdi  = 3'b101;
   localparam logic [2:0] OpMov  = 3'b110;
   localparam logic [2:0] OpHalt = 3'b111;

   typedef enum logic [2:0] {StIdle, StRead, StExec, StWb, StHalted} state_e;

   state_e              r_state;
   state_e              w_state_next;
   logic [INSTR_W-1:0]  r_instr;
   logic [ADDR_W-1:0]   r_reg1;
   logic [ADDR_W-1:0]   r_reg2;
   logic [ADDR_W-1:0]   r_reg_write;
   logic [DATA_W-1:0]   r_opa;
   logic [DATA_W-1:0]   r_opb;
   logic [DATA_W:0]     r_res;   // {carry-out, result}
   logic                r_carry;
   logic                r_zero;
   logic [DATA_W:0]     w_alu;
   logic [2:0]          w_op;
   logic                w_accept;
   logic                w_sets_carry;

   assign w_op         = r_instr[8:6];
   assign w_accept     = (r_state == StIdle) && instr_valid;
   assign w_sets_carry = (w_op == OpAdd) || (w_op == OpSub) || (w_op == OpShl);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; HALT bypasses execute and write-back.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:   if (instr_valid) w_state_next = StRead;
         StRead:   w_state_next = (w_op == OpHalt) ? StHalted : StExec;
         StExec:   w_state_next = StWb;
         StWb:     w_state_next = StIdle;
         StHalted: w_state_next = StHalted;
         default:  w_state_next = StIdle;
      endcase
   end

   // State-decoded control outputs.
   always_comb begin
      instr_ready = (r_state == StIdle);
      do_write    = (r_state == StWb);
      halted      = (r_state == StHalted);
   end

   // Latch the instruction and its read addresses on acceptance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_instr <= '0;
         r_reg1  <= '0;
         r_reg2  <= '0;
      end else if (w_accept) begin
         r_instr <= instr;
         r_reg1  <= instr[5:4];
         r_reg2  <= instr[3:2];
      end
   end

   // Capture register-file operands at the end of the read cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_opa <= '0;
         r_opb <= '0;
      end else if (r_state == StRead) begin
         r_opa <= data1;
         r_opb <= data2;
      end
   end

   // ALU: bit DATA_W carries add carry-out, subtract borrow and last bit shifted out.
   always_comb begin
      w_alu = '0;
      case (w_op)
         OpAdd:   w_alu = {1'b0, r_opa} + {1'b0, r_opb};
         OpSub:   w_alu = {1'b0, r_opa} - {1'b0, r_opb};
         OpAnd:   w_alu = {1'b0, r_opa & r_opb};
         OpXor:   w_alu = {1'b0, r_opa ^ r_opb};
         OpShl:   w_alu = {1'b0, r_opa} << r_opb[2:0];
         OpLdi:   w_alu = {1'b0, DATA_W'(r_instr[3:0])};
         OpMov:   w_alu = {1'b0, r_opb};
         default: w_alu = '0;
      endcase
   end

   // Register the result and write-back address; they hold until the next execute.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_res       <= '0;
         r_reg_write <= '0;
      end else if (r_state == StExec) begin
         r_res       <= w_alu;
         r_reg_write <= r_instr[5:4];
      end
   end

   // Flags load during write-back; carry only for arithmetic and shift.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_zero  <= 1'b0;
         r_carry <= 1'b0;
      end else if (r_state == StWb) begin
         r_zero <= (r_res[DATA_W-1:0] == '0);
         if (w_sets_carry) r_carry <= r_res[DATA_W];
      end
   end

   assign reg1       = r_reg1;
   assign reg2       = r_reg2;
   assign reg_write  = r_reg_write;
   assign write_data = r_res[DATA_W-1:0];
   assign carry      = r_carry;
   assign zero       = r_zero;

endmodule
